// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if
//   Bundles the client-side request/grant signals and the SPI_Interface strobe/data
//   signals that spi_txn_arbiter sits between.
//   modport master : arbiter view (it is the bus master of the SPI core and
//                    the grant master of the clients)
//   modport slave  : environment view (clients plus SPI core)
// Signals
//   req          N_REQ    per-requester transfer request, level, held until ack
//   req_data     8*N_REQ  TX byte, requester i uses [8i+7:8i]
//   req_ctrl     8*N_REQ  CONTROL byte, requester i uses [8i+7:8i]
//   gnt          N_REQ    one-hot current owner, zero when idle
//   ack          N_REQ    1-cycle completion pulse to the owner
//   rx_data      8        received byte, valid in the ack cycle, held until next ack
//   err          1        1-cycle timeout pulse
//   spi_write    1        WRITE strobe to SPI_Interface
//   spi_read     1        READ strobe to SPI_Interface
//   spi_control  8        CONTROL to SPI_Interface
//   spi_tx_data  8        INCOMING_DATA to SPI_Interface
//   spi_rx_data  8        OUTCOMING_DATA from SPI_Interface
//   spi_status   8        STATUS from SPI_Interface, bit0 = BUSY
interface spi_txn_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [8*N_REQ-1:0] req_ctrl;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         rx_data;
    logic               err;
    logic               spi_write;
    logic               spi_read;
    logic [7:0]         spi_control;
    logic [7:0]         spi_tx_data;
    logic [7:0]         spi_rx_data;
    logic [7:0]         spi_status;

    modport master (
        input  req, req_data, req_ctrl, spi_rx_data, spi_status,
        output gnt, ack, rx_data, err, spi_write, spi_read, spi_control, spi_tx_data
    );

    modport slave (
        output req, req_data, req_ctrl, spi_rx_data, spi_status,
        input  gnt, ack, rx_data, err, spi_write, spi_read, spi_control, spi_tx_data
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one master-mode SPI_Interface among N_REQ byte-transfer requesters.
//   Round-robin arbitration, loads TX byte + CONTROL with a WRITE strobe, waits for
//   BUSY to rise and fall, issues a READ strobe, captures the RX byte and returns it
//   to the owner with a 1-cycle ack. All outputs are registered.
// Ports
//   clk   system clock, rising edge
//   clr   asynchronous active-low reset
//   bus   spi_txn_arbiter_if.master (client request/grant side + SPI core side)
// Parameters
//   N_REQ        number of requesters (1..8)
//   TIMEOUT_CYC  cycle limit in WAIT_START/WAIT_DONE (SPI_TIMEOUT_EN builds only)
// Configuration
//   SPI_TIMEOUT_EN  when defined, a stuck wait aborts with err + ack and rx_data 8'hFF;
//                   when undefined the waits are unbounded and err stays 0.
module spi_txn_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              clr,
    spi_txn_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitStart,
        StWaitDone,
        StRead,
        StCapture
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   rr_after_owner;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [7:0]         spi_control_q, spi_control_d;
    logic [7:0]         spi_tx_data_q, spi_tx_data_d;
    logic               spi_write_q, spi_write_d;
    logic               spi_read_q, spi_read_d;
    logic               err_q, err_d;

    logic               busy;
    logic               timeout;
    logic               finish;
    logic               unused_status;

    logic [N_REQ-1:0][7:0] data_arr;
    logic [N_REQ-1:0][7:0] ctrl_arr;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [7:0]            win_data;
    logic [7:0]            win_ctrl;

    assign busy          = bus.spi_status[0];
    assign unused_status = ^bus.spi_status[7:1];
    assign data_arr      = bus.req_data;
    assign ctrl_arr      = bus.req_ctrl;

    // Round-robin: first pass scans rr_q..N_REQ-1, second pass wraps to 0..rr_q-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        win_ctrl  = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!win_found && bus.req[IDX_W'(i)] &&
                    ((pass == 0) == (i >= int'(rr_q)))) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                    win_data  = data_arr[IDX_W'(i)];
                    win_ctrl  = ctrl_arr[IDX_W'(i)];
                end
            end
        end
    end

    assign rr_after_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cleared on entry to WAIT_START (from LOAD) and WAIT_DONE (BUSY seen).
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_q == StLoad) || ((state_q == StWaitStart) && busy)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) &&
                     ((state_q == StWaitStart) || (state_q == StWaitDone));
`else
    localparam int unsigned timeout_cyc_unused = TIMEOUT_CYC;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        gnt_d         = gnt_q;
        ack_d         = '0;
        err_d         = 1'b0;
        rx_data_d     = rx_data_q;
        spi_control_d = spi_control_q;
        spi_tx_data_d = spi_tx_data_q;
        spi_write_d   = 1'b0;
        spi_read_d    = 1'b0;
        finish        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The ack cycle is skipped so a requester still holding req while
                // it sees ack is not granted twice for one transfer.
                if (win_found && (ack_q == '0)) begin
                    state_d          = StLoad;
                    owner_d          = win_idx;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    spi_tx_data_d    = win_data;
                    spi_control_d    = win_ctrl;
                    spi_write_d      = 1'b1;
                end
            end
            StLoad: begin
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (busy) begin
                    state_d = StWaitDone;
                end else if (timeout) begin
                    finish = 1'b1;
                end
            end
            StWaitDone: begin
                if (!busy) begin
                    state_d    = StRead;
                    spi_read_d = 1'b1;
                end else if (timeout) begin
                    finish = 1'b1;
                end
            end
            StRead: begin
                state_d = StCapture;
            end
            StCapture: begin
                finish    = 1'b1;
                rx_data_d = bus.spi_rx_data;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            ack_d[owner_q] = 1'b1;
            rr_d           = rr_after_owner;
            gnt_d          = '0;
            state_d        = StIdle;
            if (state_q != StCapture) begin
                err_d     = 1'b1;
                rx_data_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= StIdle;
            owner_q       <= '0;
            rr_q          <= '0;
            gnt_q         <= '0;
            ack_q         <= '0;
            err_q         <= 1'b0;
            rx_data_q     <= 8'h00;
            spi_control_q <= 8'h00;
            spi_tx_data_q <= 8'h00;
            spi_write_q   <= 1'b0;
            spi_read_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            gnt_q         <= gnt_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            rx_data_q     <= rx_data_d;
            spi_control_q <= spi_control_d;
            spi_tx_data_q <= spi_tx_data_d;
            spi_write_q   <= spi_write_d;
            spi_read_q    <= spi_read_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.spi_control = spi_control_q;
    assign bus.spi_tx_data = spi_tx_data_q;
    assign bus.spi_write   = spi_write_q;
    assign bus.spi_read    = spi_read_q;
endmodule
